// File: rtl/mpu_sampler.sv
// Periodic MPU6050 register-burst sampler driving a byte-level I2C master.
// Define MPU_WHOAMI_CHECK_EN to verify WHO_AM_I (0x75 == 0x68) before waking the device.
module mpu_sampler #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h68,
  parameter int unsigned NUM_REGS   = 14,
  parameter logic [7:0]  BASE_REG   = 8'h3B,
  parameter int unsigned PERIOD     = 500,
  parameter int unsigned TIMEOUT    = 1000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  output logic                  i2c_req_o,
  output logic                  i2c_rw_o,
  output logic [6:0]            i2c_slave_addr_o,
  output logic [7:0]            i2c_reg_addr_o,
  output logic [7:0]            i2c_wdata_o,
  input  logic                  i2c_done_i,
  input  logic                  i2c_nack_i,
  input  logic [7:0]            i2c_rdata_i,
  output logic [NUM_REGS*8-1:0] sample_data_o,
  output logic                  sample_valid_o,
  output logic                  busy_o,
  output logic                  error_o
);

  localparam int unsigned IdxW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned SelW = $clog2(NUM_REGS * 8);
  localparam int unsigned CntW = $clog2(PERIOD + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    StIdle, StCheck, StWake, StWait, StRead, StPublish, StError
  } state_e;

  state_e                state_q;
  logic [IdxW-1:0]       idx_q;
  logic [CntW-1:0]       cnt_q;
  logic [CntW-1:0]       el_q;
  logic [TmoW-1:0]       tmo_q;
  logic                  req_q;
  logic                  rw_q;
  logic [7:0]            reg_q;
  logic [7:0]            wdata_q;
  logic [NUM_REGS*8-1:0] shadow_q;
  logic [NUM_REGS*8-1:0] data_q;
  logic                  valid_q;
  logic                  error_q;

  logic                  txn_rw;
  logic [7:0]            txn_reg;
  logic [7:0]            txn_wdata;
  logic [SelW-1:0]       sel;
  logic [NUM_REGS*8-1:0] shadow_merged;
  logic [CntW-1:0]       reload;
  logic [31:0]           el_ext;
  logic                  timeout_hit;

  always_comb begin
    txn_rw    = 1'b1;
    txn_reg   = BASE_REG + 8'(idx_q);
    txn_wdata = 8'h00;
    if (state_q == StWake) begin
      txn_rw  = 1'b0;
      txn_reg = 8'h6B;
    end
`ifdef MPU_WHOAMI_CHECK_EN
    if (state_q == StCheck) begin
      txn_reg = 8'h75;
    end
`endif
  end

  always_comb begin
    sel           = SelW'({idx_q, 3'b000});
    shadow_merged = shadow_q;
    shadow_merged[sel +: 8] = i2c_rdata_i;
  end

  // el_q counts edges since the burst started; the WAIT reload keeps starts PERIOD apart.
  always_comb begin
    el_ext = 32'(el_q);
    if (el_ext + 32'd2 >= PERIOD) begin
      reload = '0;
    end else begin
      reload = CntW'(PERIOD - 32'd2 - el_ext);
    end
    timeout_hit = (tmo_q == TmoW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      cnt_q    <= '0;
      el_q     <= '0;
      tmo_q    <= '0;
      req_q    <= 1'b0;
      rw_q     <= 1'b1;
      reg_q    <= 8'h00;
      wdata_q  <= 8'h00;
      shadow_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!enable_i) begin
        state_q <= StIdle;
        req_q   <= 1'b0;
        error_q <= 1'b0;
      end else begin
        if (el_q != CntW'(PERIOD)) begin
          el_q <= el_q + 1'b1;
        end
        unique case (state_q)
          StIdle: begin
`ifdef MPU_WHOAMI_CHECK_EN
            state_q <= StCheck;
`else
            state_q <= StWake;
`endif
          end
`ifdef MPU_WHOAMI_CHECK_EN
          StCheck, StWake, StRead: begin
`else
          StWake, StRead: begin
`endif
            if (!req_q) begin
              req_q   <= 1'b1;
              tmo_q   <= '0;
              rw_q    <= txn_rw;
              reg_q   <= txn_reg;
              wdata_q <= txn_wdata;
            end else if (i2c_done_i) begin
              req_q <= 1'b0;
              if (i2c_nack_i) begin
                state_q <= StError;
                error_q <= 1'b1;
`ifdef MPU_WHOAMI_CHECK_EN
              end else if (state_q == StCheck) begin
                if (i2c_rdata_i == 8'h68) begin
                  state_q <= StWake;
                end else begin
                  state_q <= StError;
                  error_q <= 1'b1;
                end
`endif
              end else if (state_q == StWake) begin
                state_q <= StWait;
                cnt_q   <= CntW'(PERIOD - 1);
              end else begin
                shadow_q <= shadow_merged;
                if (idx_q == IdxLast) begin
                  data_q  <= shadow_merged;
                  valid_q <= 1'b1;
                  state_q <= StPublish;
                end else begin
                  idx_q <= idx_q + 1'b1;
                end
              end
            end else if (timeout_hit) begin
              req_q   <= 1'b0;
              state_q <= StError;
              error_q <= 1'b1;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end
          StWait: begin
            if (cnt_q == '0) begin
              state_q <= StRead;
              idx_q   <= '0;
              el_q    <= '0;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          StPublish: begin
            state_q <= StWait;
            cnt_q   <= reload;
          end
          StError: begin
            req_q   <= 1'b0;
            error_q <= 1'b1;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign i2c_req_o        = req_q;
  assign i2c_rw_o         = rw_q;
  assign i2c_slave_addr_o = SLAVE_ADDR;
  assign i2c_reg_addr_o   = reg_q;
  assign i2c_wdata_o      = wdata_q;
  assign sample_data_o    = data_q;
  assign sample_valid_o   = valid_q;
  assign busy_o           = (state_q != StIdle) && (state_q != StError);
  assign error_o          = error_q;

endmodule

// File: tb/tb_mpu_sampler.sv
// Bench for mpu_sampler: scenario table plus hand sequences against a transaction-list model.
module tb_mpu_sampler;

  localparam int unsigned NRegs  = 14;
  localparam logic [7:0]  Base   = 8'h3B;
  localparam int unsigned Period = 500;
  localparam int unsigned Tmo    = 1000;
`ifdef MPU_WHOAMI_CHECK_EN
  localparam int Pre = 1;
`else
  localparam int Pre = 0;
`endif

  typedef struct packed {logic rw; logic [7:0] addr; logic [7:0] wdata;} txn_t;
  typedef struct {int lat; int nack_txn; logic [7:0] who; bit exp_err; bit exp_pub;} vec_t;

  logic clk = 1'b0;
  logic rst_ni, en_a, en_b;
  logic req_a, rw_a, done_a, nack_a, valid_a, busy_a, err_a;
  logic [6:0] sa_a, sa_b;
  logic [7:0] reg_a, wdata_a, rdata_a;
  logic [NRegs*8-1:0] data_a;
  logic req_b, rw_b, done_b, nack_b, valid_b, busy_b, err_b;
  logic [7:0] reg_b, wdata_b, rdata_b;
  logic [31:0] data_b;

  mpu_sampler u_dut (
    .clk_i(clk), .rst_ni(rst_ni), .enable_i(en_a),
    .i2c_req_o(req_a), .i2c_rw_o(rw_a), .i2c_slave_addr_o(sa_a), .i2c_reg_addr_o(reg_a),
    .i2c_wdata_o(wdata_a), .i2c_done_i(done_a), .i2c_nack_i(nack_a), .i2c_rdata_i(rdata_a),
    .sample_data_o(data_a), .sample_valid_o(valid_a), .busy_o(busy_a), .error_o(err_a)
  );

  mpu_sampler #(.NUM_REGS(4), .BASE_REG(8'hFE), .PERIOD(12), .TIMEOUT(8)) u_dut_wrap (
    .clk_i(clk), .rst_ni(rst_ni), .enable_i(en_b),
    .i2c_req_o(req_b), .i2c_rw_o(rw_b), .i2c_slave_addr_o(sa_b), .i2c_reg_addr_o(reg_b),
    .i2c_wdata_o(wdata_b), .i2c_done_i(done_b), .i2c_nack_i(nack_b), .i2c_rdata_i(rdata_b),
    .sample_data_o(data_b), .sample_valid_o(valid_b), .busy_o(busy_b), .error_o(err_b)
  );

  initial forever #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Device model: register file, response latency, NACK injection, transaction log.
  logic [7:0] mem [256];
  int lat = 0;
  int nack_txn = -1;
  logic [7:0] who = 8'h68;
  txn_t log_q[$];
  txn_t logb_q[$];

  function automatic txn_t exp_txn(input int i, input logic [7:0] base);
    txn_t t;
    t.wdata = 8'h00;
    if (Pre == 1 && i == 0) begin
      t.rw = 1'b1; t.addr = 8'h75;
    end else if (i == Pre) begin
      t.rw = 1'b0; t.addr = 8'h6B;
    end else begin
      t.rw = 1'b1; t.addr = base + 8'(i - Pre - 1);
    end
    return t;
  endfunction

  function automatic bit txn_ok(input txn_t got, input txn_t want);
    return got.rw == want.rw && got.addr == want.addr && (got.rw || got.wdata == want.wdata);
  endfunction

  function automatic logic [NRegs*8-1:0] model_a();
    logic [NRegs*8-1:0] s;
    for (int k = 0; k < int'(NRegs); k++) s[8*k +: 8] = mem[8'(int'(Base) + k)];
    return s;
  endfunction

  initial begin
    bit prev, resp;
    int wcnt;
    txn_t t;
    done_a = 1'b0; nack_a = 1'b0; rdata_a = 8'h00;
    prev = 1'b0; resp = 1'b0; wcnt = 0;
    forever begin
      @(negedge clk);
      done_a = 1'b0;
      nack_a = 1'b0;
      if (req_a && !prev) begin
        t.rw = rw_a; t.addr = reg_a; t.wdata = wdata_a;
        log_q.push_back(t);
        resp = 1'b0;
        wcnt = 0;
      end
      if (req_a && !resp && log_q.size() > 0) begin
        if (wcnt >= lat) begin
          t = log_q[$];
          check("hold_fields", {rw_a, reg_a, wdata_a}, {t.rw, t.addr, t.wdata});
          done_a = 1'b1;
          resp   = 1'b1;
          nack_a = (int'(log_q.size()) - 1 == nack_txn);
          rdata_a = (Pre == 1 && log_q.size() == 1) ? who : mem[t.addr];
        end else begin
          wcnt++;
        end
      end
      prev = req_a;
    end
  end

  initial begin
    bit prev;
    txn_t t;
    done_b = 1'b0; nack_b = 1'b0; rdata_b = 8'h00; prev = 1'b0;
    forever begin
      @(negedge clk);
      done_b = 1'b0;
      if (req_b && !prev) begin
        t.rw = rw_b; t.addr = reg_b; t.wdata = wdata_b;
        logb_q.push_back(t);
        done_b  = 1'b1;
        rdata_b = (reg_b == 8'h75) ? 8'h68 : (reg_b ^ 8'hA5);
      end
      prev = req_b;
    end
  end

  task automatic restart_a();
    en_a = 1'b0;
    repeat (3) @(negedge clk);
    log_q.delete();
    en_a = 1'b1;
  endtask

  task automatic wait_valid_a(input int budget, output int t);
    t = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (valid_a) begin
        t = cyc;
        break;
      end
    end
  endtask

  vec_t vecs[6];
  logic [NRegs*8-1:0] last_sample;

  initial begin
    int t1, t2, t3, n, explen;
    bit pub, err, ok;
    logic [31:0] exp_b;

    vecs[0] = '{0, -1, 8'h68, 1'b0, 1'b1};
    vecs[1] = '{3, -1, 8'h68, 1'b0, 1'b1};
    vecs[2] = '{0, Pre + 5, 8'h68, 1'b1, 1'b0};
    vecs[3] = '{1, Pre + 1, 8'h68, 1'b1, 1'b0};
    vecs[4] = '{0, Pre, 8'h68, 1'b1, 1'b0};
`ifdef MPU_WHOAMI_CHECK_EN
    vecs[5] = '{0, -1, 8'h70, 1'b1, 1'b0};
`else
    vecs[5] = '{2, -1, 8'h70, 1'b0, 1'b1};
`endif
    last_sample = '0;

    rst_ni = 1'b0; en_a = 1'b0; en_b = 1'b0;
    #12;
    check("rst_outs", {req_a, valid_a, busy_a, err_a, rw_a}, 5'b00001);
    check("rst_regs", {reg_a, wdata_a}, 16'h0000);
    check("rst_data", data_a, '0);
    check("slave_addr", sa_a, 7'h68);
    @(negedge clk);
    rst_ni = 1'b1;

    for (int v = 0; v < 6; v++) begin
      lat = vecs[v].lat; nack_txn = vecs[v].nack_txn; who = vecs[v].who;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      restart_a();
      pub = 1'b0; err = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        @(negedge clk);
        if (valid_a) begin pub = 1'b1; break; end
        if (err_a) begin err = 1'b1; break; end
      end
      check($sformatf("v%0d_error", v), err_a, vecs[v].exp_err);
      check($sformatf("v%0d_published", v), pub, vecs[v].exp_pub);
      check($sformatf("v%0d_data", v), data_a, vecs[v].exp_pub ? model_a() : last_sample);
      check($sformatf("v%0d_busy", v), busy_a, !vecs[v].exp_err);
      if (vecs[v].exp_pub) explen = Pre + 1 + int'(NRegs);
      else if (vecs[v].nack_txn >= 0) explen = vecs[v].nack_txn + 1;
      else explen = 1;
      ok = (int'(log_q.size()) == explen);
      for (int i = 0; i < int'(log_q.size()); i++) if (!txn_ok(log_q[i], exp_txn(i, Base))) ok = 1'b0;
      check($sformatf("v%0d_txn_seq", v), ok, 1'b1);
      if (vecs[v].exp_pub) begin
        last_sample = model_a();
        @(negedge clk);
        check($sformatf("v%0d_valid_one_cycle", v), valid_a, 1'b0);
      end
    end

    // Instant-done master: publishes exactly PERIOD apart.
    lat = 0; nack_txn = -1; who = 8'h68;
    restart_a();
    wait_valid_a(3000, t1);
    wait_valid_a(1000, t2);
    wait_valid_a(1000, t3);
    check("period_1", t2 - t1, Period);
    check("period_2", t3 - t2, Period);
    check("period_data", data_a, model_a());
    last_sample = model_a();

    // Slow master overruns PERIOD: next burst follows after PUBLISH and one WAIT cycle.
    lat = 38;
    restart_a();
    wait_valid_a(5000, t1);
    wait_valid_a(2000, t2);
    check("back_to_back", t2 - t1, NRegs * (38 + 2) + 2);
    check("b2b_data", data_a, model_a());
    last_sample = model_a();

    // Enable dropped mid-transaction.
    lat = 5;
    restart_a();
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (log_q.size() >= Pre + 3 && req_a) begin ok = 1'b1; break; end
    end
    check("en_drop_reached", ok, 1'b1);
    en_a = 1'b0;
    @(negedge clk);
    check("en_drop_req", {req_a, busy_a}, 2'b00);
    check("en_drop_data", data_a, last_sample);

    // Withheld done: error exactly TIMEOUT cycles after the request rises.
    lat = 1 << 30;
    restart_a();
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_a) begin ok = 1'b1; break; end
    end
    check("tmo_req_seen", ok, 1'b1);
    n = 0;
    for (int c = 0; c < Tmo + 100; c++) begin
      @(negedge clk);
      n++;
      if (err_a) break;
    end
    check("tmo_cycles", n, Tmo);
    check("tmo_err_state", {err_a, req_a, busy_a}, 3'b100);
    en_a = 1'b0;
    @(negedge clk);
    check("tmo_clear", {err_a, busy_a}, 2'b00);
    check("tmo_data", data_a, last_sample);

    // Reset during a burst read.
    lat = 2;
    restart_a();
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (log_q.size() >= Pre + 4) begin ok = 1'b1; break; end
    end
    check("rst_mid_reached", ok, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    check("rst_mid_outs", {req_a, valid_a, busy_a, err_a, rw_a}, 5'b00001);
    check("rst_mid_regs", {reg_a, wdata_a}, 16'h0000);
    check("rst_mid_data", data_a, '0);
    @(negedge clk);
    log_q.delete();
    rst_ni = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (log_q.size() >= 1) begin ok = 1'b1; break; end
    end
    check("rst_restart", ok && txn_ok(log_q[0], exp_txn(0, Base)), 1'b1);
    en_a = 1'b0;

    // Second instance: address wrap FE,FF,00,01 and a short period.
    logb_q.delete();
    en_b = 1'b1;
    t1 = -1; t2 = -1; t3 = -1; n = 0;
    for (int c = 0; c < 200 && n < 3; c++) begin
      @(negedge clk);
      if (valid_b) begin
        if (n == 0) t1 = cyc; else if (n == 1) t2 = cyc; else t3 = cyc;
        n++;
      end
    end
    check("wrap_period_1", t2 - t1, 12);
    check("wrap_period_2", t3 - t2, 12);
    for (int k = 0; k < 4; k++) exp_b[8*k +: 8] = (8'hFE + 8'(k)) ^ 8'hA5;
    check("wrap_data", data_b, exp_b);
    ok = (logb_q.size() >= Pre + 5);
    for (int i = 0; i < Pre + 5 && i < int'(logb_q.size()); i++)
      if (!txn_ok(logb_q[i], exp_txn(i, 8'hFE))) ok = 1'b0;
    check("wrap_txn_seq", ok, 1'b1);
    check("wrap_no_error", err_b, 1'b0);
    en_b = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mpu_sampler.md
MPU_SAMPLER -- requirements
Module: mpu_sampler

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'h68, I2C address of the MPU6050 (AD0 = GND) used for every transaction.
REQ-002 Parameter NUM_REGS, default 14, number of consecutive registers read per sample (range 1-32).
REQ-003 Parameter BASE_REG, default 8'h3B, first register of each sample burst.
REQ-004 Parameter PERIOD, default 500, clk cycles from one sample start to the next (minimum 2).
REQ-005 Parameter TIMEOUT, default 1000, maximum clk cycles allowed per transaction before failure.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 enable  in  1  run request; low returns the block to IDLE.
REQ-009 i2c_req  out  1  transaction request to the I2C master.
REQ-010 i2c_rw  out  1  0 = write, 1 = read.
REQ-011 i2c_slave_addr  out  7  always SLAVE_ADDR.
REQ-012 i2c_reg_addr  out  8  target register.
REQ-013 i2c_wdata  out  8  write byte.
REQ-014 i2c_done  in  1  one-cycle completion pulse from the master.
REQ-015 i2c_nack  in  1  qualifies i2c_done; high = slave did not acknowledge.
REQ-016 i2c_rdata  in  8  read byte, valid with i2c_done.
REQ-017 sample_data  out  NUM_REGS*8  last complete sample; register BASE_REG+k in bits [8k+7:8k].
REQ-018 sample_valid  out  1  one-cycle pulse when sample_data updates.
REQ-019 busy  out  1  high in any state other than IDLE and ERROR.
REQ-020 error  out  1  sticky failure flag.

Function
REQ-021 States: IDLE, CHECK, WAKE, WAIT, READ, PUBLISH, ERROR.
REQ-022 IDLE -> (CHECK when MPU_WHOAMI_CHECK_EN is defined, else WAKE) on enable high.
REQ-023 CHECK: read reg 8'h75; rdata == 8'h68 -> WAKE, any other value -> ERROR.
REQ-024 WAKE: write 8'h00 to reg 8'h6B; done -> WAIT with period counter loaded to PERIOD-1.
REQ-025 WAIT: counter decrements each cycle; on 0 -> READ with index 0.
REQ-026 READ: one single-byte read per index, reg address BASE_REG+index (8-bit wrap at 8'hFF -> 8'h00); result written to shadow buffer; after index NUM_REGS-1 -> PUBLISH.
REQ-027 PUBLISH: shadow copied to sample_data, sample_valid pulses for exactly that cycle, -> WAIT; counter reloaded so consecutive sample starts are PERIOD cycles apart, or immediately back-to-back if the burst exceeded PERIOD.
REQ-028 Handshake: i2c_req rises in the cycle after the state/index is entered; i2c_rw, i2c_reg_addr and i2c_wdata stay stable while i2c_req is high; i2c_req falls in the cycle after i2c_done; i2c_done while i2c_req is low is ignored.
REQ-029 Timeout counter restarts at each i2c_req rise; reaching TIMEOUT with no i2c_done -> ERROR.
REQ-030 i2c_done with i2c_nack high -> ERROR; partial shadow data is never published.
REQ-031 ERROR: i2c_req low, error high; held until enable is low, which clears error and -> IDLE.
REQ-032 enable low in any state: i2c_req drops next cycle, -> IDLE, sample_data retained.
REQ-033 Simultaneous i2c_done and timeout expiry in the same cycle: done takes priority.

Reset
REQ-034 On rst low: state IDLE; i2c_req, sample_valid, busy, error = 0; i2c_rw = 1; i2c_reg_addr, i2c_wdata = 0; sample_data = 0; counters = 0.
REQ-035 Reset asserted mid-transaction aborts immediately with no further output change; the block restarts from IDLE after release.

Configuration
REQ-036 Macro MPU_WHOAMI_CHECK_EN defined: CHECK state compiled in and executed once per enable.
REQ-037 Macro undefined: CHECK logic absent; IDLE goes directly to WAKE.

Verification
REQ-038 Macro defined, master model returns 8'h68, then bytes 8'h00-8'h0D -> write 8'h00 to 8'h6B issued, reads 8'h3B-8'h48 in order, sample_data = 112'h0D0C...0100, sample_valid pulses once.
REQ-039 Macro defined, WHO_AM_I returns 8'h70 -> error = 1, no write to 8'h6B, busy = 0.
REQ-040 NACK on the 5th burst read -> ERROR, sample_data unchanged from the previous sample, sample_valid never pulses.
REQ-041 Master withholds i2c_done for TIMEOUT cycles -> error set on cycle TIMEOUT; enable low -> error cleared, IDLE.
REQ-042 PERIOD = 500, instant-done master -> sample_valid pulses exactly 500 cycles apart; BASE_REG = 8'hFE, NUM_REGS = 4 -> addresses FE, FF, 00, 01.
REQ-043 rst low during READ -> all outputs at reset values in the same cycle; after release with enable high, the sequence restarts at CHECK/WAKE.
